apple2_paddle_timer: RTL and testbench
======================================

# apple2_paddle_timer

Gameport paddle timer modelling the Apple II 558 quad one-shot. It converts signed analog joystick axes into four paddle timeout bits (PDL0–PDL3) for the core's GAMEPORT[7:4] inputs. Each one-shot is retriggered by the core's PDL_STROBE (C07x read) and counted down on rising edges of CLK_2M. The block sits between the joystick inputs from the top level and the apple2 core's GAMEPORT bus.

## Interface
Parameters:
- CENTER, 2800: count loaded for axis value 0.
- SCALE, 22: counts per axis LSB.
- CLAMP_THRESH, 5590: any computed count ≥ this is forced to MAX_COUNT.
- MAX_COUNT, 5650: saturated full-scale count.

Ports:
- CLK_14M  in  1  14.31818 MHz master clock; the only clock.
- reset  in  1  asynchronous, active-high.
- CLK_2M  in  1  CPU-rate clock level from the core, sampled as a data signal in the CLK_14M domain.
- PDL_STROBE  in  1  high while C07x is read; may be high for several CLK_14M cycles.
- joy_an0  in  16  stick 0: [15:8] X → PDL0, [7:0] Y → PDL1, each two's-complement.
- joy_an1  in  16  stick 1: [15:8] X → PDL2, [7:0] Y → PDL3, each two's-complement.
- pdl_out  out  4  one-shot outputs; bit n = PDLn.
- busy  out  1  OR of pdl_out.

## Operation
- Edge detect: register clk2m_d <= CLK_2M every CLK_14M cycle. An edge cycle is CLK_2M=1 and clk2m_d=0. All counting happens only on edge cycles.
- Strobe latch: pending <= 1 on any cycle with PDL_STROBE=1. Pending clears on an edge cycle.
- load = edge & (pending | PDL_STROBE). A strobe coinciding with an edge loads on that edge.
- Per channel n, on each edge cycle, evaluated on the pre-edge count:
  - if count>0: pdl_out[n] <= 1 and count <= count-1.
  - else: pdl_out[n] <= 0.
  - if load: count <= clamp(n). The load overrides the decrement; pdl_out[n] still follows the pre-load count.
- clamp(n):
  - v = CENTER + SCALE*sext(axis).
  - Compute in ≥15-bit signed arithmetic. Range is −16..5594.
  - If v<0 the result is 0. If v≥CLAMP_THRESH the result is MAX_COUNT. Otherwise the result is v.
  - The count register is 13 bits unsigned.
- All four channels load together from one strobe. Axis inputs are sampled only at load; changes mid-count are ignored.
- Retrigger: a load while count>0 restarts the channel from the new value with no low glitch on pdl_out.
- busy is registered, or derived combinationally from registered pdl_out.

## Timing
- Reset values: pdl_out=0, busy=0, all counts=0, pending=0, clk2m_d=0.
- Reset asserted mid-count drops all outputs immediately (asynchronous reset). After release, nothing rises until a new strobe is followed by an edge.
- A load with value N gives:
  - pdl_out[n]=1 from the first edge after the load edge through edge N.
  - pdl_out[n]=0 from edge N+1.
  - Total high time is exactly N edge periods.
- N=0: the output never rises.
- Outputs change only on edge cycles, one CLK_14M cycle after CLK_2M is seen high.
- Strobe asserted for many cycles between edges causes exactly one load.
- Strobe held across an edge causes a load on that edge, plus one more load on the next edge if the strobe is still high after the first edge.
- Irregular CLK_2M periods (long cycle) do not matter; only edges are counted.

## Test plan
- Reset, then axis 0 on all channels, strobe one cycle → each pdl_out high for exactly 2800 edges, then 0; busy mirrors.
- X=+127 (0x7F), Y=−128 (0x80), strobe:
  - PDL0 high for 5650 edges (5594 clamped).
  - PDL1 never rises.
- X=−1 → 2778 edges; X=+126 → 5572 edges (below threshold, no clamp).
- Strobe at edge 1000 of an axis-0 countdown with the axis changed to +10 → output stays high with no gap, then runs 3020 more edges.
- Assert reset at edge 500 of a countdown → pdl_out=0 within the same cycle, stays 0 after release with no strobe.
- Strobe coinciding with an edge cycle, and a 20-cycle strobe between edges → exactly one load in each case, verified by high duration equal to N.

Source files
------------

// File: rtl/apple2_paddle_timer_if.sv
// Gameport paddle timer bus: 2 MHz clock level, strobe, joystick axes in; one-shot bits out.
interface apple2_paddle_timer_if;
    logic        CLK_2M;
    logic        PDL_STROBE;
    logic [15:0] joy_an0;
    logic [15:0] joy_an1;
    logic [3:0]  pdl_out;
    logic        busy;

    modport master (
        output CLK_2M, PDL_STROBE, joy_an0, joy_an1,
        input  pdl_out, busy
    );

    modport slave (
        input  CLK_2M, PDL_STROBE, joy_an0, joy_an1,
        output pdl_out, busy
    );
endinterface

// File: rtl/apple2_paddle_timer.sv
// Apple II 558 quad one-shot model: four paddle timers retriggered by PDL_STROBE
// and counted down on rising edges of CLK_2M, sampled in the CLK_14M domain.
module apple2_paddle_timer #(
    parameter int CENTER       = 2800,
    parameter int SCALE        = 22,
    parameter int CLAMP_THRESH = 5590,
    parameter int MAX_COUNT    = 5650
) (
    input  logic                  CLK_14M,
    input  logic                  reset,
    apple2_paddle_timer_if.slave  gp
);

    localparam int unsigned CNT_W  = 13;
    localparam int unsigned CALC_W = 16;
    localparam int unsigned AXIS_W = 8;
    localparam int unsigned NCH    = 4;

    logic                 r_clk2m_d;
    logic                 r_pending;
    logic [CNT_W-1:0]     r_count [NCH];
    logic [NCH-1:0]       r_pdl;
    logic                 r_busy;

    logic                 w_edge;
    logic                 w_load;
    logic [AXIS_W-1:0]    w_axis  [NCH];
    logic [CNT_W-1:0]     w_clamp [NCH];
    logic [NCH-1:0]       w_nz;

    // Axis value to count: CENTER + SCALE*axis, floored at 0 and saturated near full scale.
    function automatic logic [CNT_W-1:0] f_clamp(input logic [AXIS_W-1:0] axis);
        logic signed [CALC_W-1:0] v;
        v = CALC_W'(CENTER) + CALC_W'(SCALE) * CALC_W'($signed(axis));
        if (v < 0)
            return '0;
        else if (v >= CALC_W'(CLAMP_THRESH))
            return CNT_W'(MAX_COUNT);
        else
            return CNT_W'(v);
    endfunction

    assign w_edge = gp.CLK_2M & ~r_clk2m_d;
    assign w_load = w_edge & (r_pending | gp.PDL_STROBE);

    assign w_axis[0] = gp.joy_an0[15:8];
    assign w_axis[1] = gp.joy_an0[7:0];
    assign w_axis[2] = gp.joy_an1[15:8];
    assign w_axis[3] = gp.joy_an1[7:0];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_clamp[i] = f_clamp(w_axis[i]);
            w_nz[i]    = (r_count[i] != '0);
        end
    end

    // Strobe latch and edge detect; pending clears on every edge so a held strobe re-arms afterwards.
    always_ff @(posedge CLK_14M or posedge reset) begin
        if (reset) begin
            r_clk2m_d <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_clk2m_d <= gp.CLK_2M;
            if (w_edge)
                r_pending <= 1'b0;
            else if (gp.PDL_STROBE)
                r_pending <= 1'b1;
        end
    end

    // Outputs follow the pre-edge count, so a retrigger mid-count never glitches low.
    always_ff @(posedge CLK_14M or posedge reset) begin
        if (reset) begin
            r_pdl  <= '0;
            r_busy <= 1'b0;
            for (int i = 0; i < NCH; i++)
                r_count[i] <= '0;
        end else if (w_edge) begin
            r_pdl  <= w_nz;
            r_busy <= |w_nz;
            for (int i = 0; i < NCH; i++) begin
                if (w_load)
                    r_count[i] <= w_clamp[i];
                else if (w_nz[i])
                    r_count[i] <= r_count[i] - CNT_W'(1);
            end
        end
    end

    assign gp.pdl_out = r_pdl;
    assign gp.busy    = r_busy;

endmodule

// File: tb/tb_apple2_paddle_timer.sv
// Directed bench for apple2_paddle_timer: expected durations queued at load, compared after countdown.
module tb_apple2_paddle_timer;

    logic clk = 1'b0;
    logic rst;

    apple2_paddle_timer_if gp();

    apple2_paddle_timer dut (
        .CLK_14M (clk),
        .reset   (rst),
        .gp      (gp)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    function automatic int model(input logic [7:0] a);
        int v;
        v = 2800 + 22 * int'($signed(a));
        if (v < 0) return 0;
        if (v >= 5590) return 5650;
        return v;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set axes and queue the expected high duration of each channel.
    task automatic arm(input logic [15:0] j0, input logic [15:0] j1);
        gp.joy_an0 = j0;
        gp.joy_an1 = j1;
        exp_q.push_back(model(j0[15:8]));
        exp_q.push_back(model(j0[7:0]));
        exp_q.push_back(model(j1[15:8]));
        exp_q.push_back(model(j1[7:0]));
    endtask

    // One CLK_2M rising edge, then low for low_cycles CLK_14M cycles.
    task automatic edge2m(input int low_cycles, input bit strb);
        gp.CLK_2M     = 1'b1;
        gp.PDL_STROBE = strb;
        tick();
        gp.CLK_2M     = 1'b0;
        gp.PDL_STROBE = 1'b0;
        repeat (low_cycles) tick();
    endtask

    task automatic strobe(input int cycles);
        gp.PDL_STROBE = 1'b1;
        repeat (cycles) tick();
        gp.PDL_STROBE = 1'b0;
    endtask

    // Load edge, then count edges each channel stays high; checks durations, gaps and busy.
    task automatic measure(input string tag, input logic [3:0] load_exp,
                           input int lowmax, input bit scramble, input bit strb_on_load);
        int hi[4];
        bit fell[4];
        int gaps, busy_hi, n, e, maxexp;
        for (int c = 0; c < 4; c++) begin hi[c] = 0; fell[c] = 1'b0; end
        gaps = 0; busy_hi = 0; n = 0; maxexp = 0;
        edge2m(1, strb_on_load);
        check({tag, "_load_edge"}, int'(gp.pdl_out), int'(load_exp));
        if (scramble) begin
            gp.joy_an0 = 16'($urandom);
            gp.joy_an1 = 16'($urandom);
        end
        do begin
            edge2m(int'($urandom_range(lowmax, 1)), 1'b0);
            n++;
            for (int c = 0; c < 4; c++) begin
                if (gp.pdl_out[c]) begin
                    hi[c]++;
                    if (fell[c]) gaps++;
                end else begin
                    fell[c] = 1'b1;
                end
            end
            if (gp.busy) busy_hi++;
        end while (gp.pdl_out != 4'h0 && n < 6000);
        check({tag, "_timeout"}, int'(n >= 6000), 0);
        for (int c = 0; c < 4; c++) begin
            e = exp_q.pop_front();
            if (e > maxexp) maxexp = e;
            check($sformatf("%s_pdl%0d_len", tag, c), hi[c], e);
        end
        check({tag, "_gaps"}, gaps, 0);
        check({tag, "_busy_len"}, busy_hi, maxexp);
    endtask

    initial begin
        int e, hits;
        rst           = 1'b1;
        gp.CLK_2M     = 1'b0;
        gp.PDL_STROBE = 1'b0;
        gp.joy_an0    = '0;
        gp.joy_an1    = '0;
        repeat (3) tick();
        check("reset_pdl", int'(gp.pdl_out), 0);
        check("reset_busy", int'(gp.busy), 0);
        rst = 1'b0;
        repeat (2) edge2m(1, 1'b0);
        check("idle_pdl", int'(gp.pdl_out), 0);

        // Centered axes; inputs scrambled mid-count must be ignored.
        arm(16'h0000, 16'h0000);
        strobe(1);
        measure("axis0", 4'h0, 1, 1'b1, 1'b0);

        // Saturation and floor.
        arm(16'h7F80, 16'h7E01);
        strobe(1);
        measure("extremes", 4'h0, 1, 1'b0, 1'b0);

        // Small offsets with irregular CLK_2M periods.
        arm(16'hFF00, 16'h0AF6);
        strobe(1);
        measure("irregular", 4'h0, 4, 1'b0, 1'b0);

        arm(16'h7E7F, 16'h0101);
        strobe(1);
        measure("near_thresh", 4'h0, 1, 1'b0, 1'b0);

        // Retrigger at edge 1000 with axis +10.
        arm(16'h0000, 16'h0000);
        strobe(1);
        edge2m(1, 1'b0);
        repeat (1000) edge2m(1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            e = exp_q.pop_front();
            check($sformatf("retrig_pre_pdl%0d", c), int'(gp.pdl_out[c]), int'(e >= 1000));
        end
        arm(16'h0A0A, 16'h0A0A);
        strobe(1);
        measure("retrig", 4'hF, 1, 1'b0, 1'b0);

        // Asynchronous reset mid-count.
        arm(16'h0000, 16'h0000);
        strobe(1);
        edge2m(1, 1'b0);
        repeat (500) edge2m(1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            e = exp_q.pop_front();
            check($sformatf("rst_pre_pdl%0d", c), int'(gp.pdl_out[c]), int'(e >= 500));
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pdl", int'(gp.pdl_out), 0);
        check("async_rst_busy", int'(gp.busy), 0);
        tick();
        rst = 1'b0;
        hits = 0;
        repeat (300) begin
            edge2m(1, 1'b0);
            if (gp.pdl_out != 4'h0 || gp.busy) hits++;
        end
        check("post_rst_quiet", hits, 0);

        // Strobe coinciding with an edge: exactly one load.
        arm(16'h9C9C, 16'h889C);
        measure("strobe_on_edge", 4'h0, 1, 1'b0, 1'b1);

        // Long strobe between edges: exactly one load.
        arm(16'h8888, 16'h9C88);
        strobe(20);
        measure("long_strobe", 4'h0, 1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
